seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Time-multiplexed 8-digit seven-segment driver that consumes the BCD wall-clock digits produced by the clock counters (hour, minute, second, two BCD digits each) and renders them as `HH-MM-SS`. It scans one digit position at a time, snapshots the time once per frame to prevent tearing, and supports per-field blinking for time-setting UI and 8-level brightness by PWM. It sits between the clock counter block and the board's common-anode display pins.

## Interface
- `SCAN_DIV`, 100_000: clk cycles per digit slot. Must be a multiple of 8 and at least 8.
- `BLINK_DIV`, 50_000_000: clk cycles per blink half-period.
- `clk` in 1: single clock; all state on posedge.
- `resetn` in 1: asynchronous, active-low reset.
- `hour` in [1:0][3:0]: BCD hour; [1] tens, [0] units.
- `minute` in [1:0][3:0]: BCD minute, same layout.
- `second` in [1:0][3:0]: BCD second, same layout.
- `blink_sel` in 2: field to blink. 00 none, 01 hour, 10 minute, 11 second.
- `brightness` in 3: lit sub-slots per digit slot, minus 1. 7 is full on.
- `an` out 8: digit enables, active-low; `an[i]` selects position i.
- `seg` out 7: segments, active-low; `seg[0]`=a … `seg[6]`=g.

## Operation
- **Digit positions:**
  - 0 = S0, 1 = S1, 2 = dash.
  - 3 = M0, 4 = M1, 5 = dash.
  - 6 = H0, 7 = H1.
- **Scan counter `scan_cnt`:**
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, digit index `pos` advances, 7 wraps to 0.
- **Snapshot:**
  - A six-digit register captures hour, minute and second on the first posedge after `resetn` deasserts.
  - It recaptures on every cycle where `pos`==7 and `scan_cnt`==SCAN_DIV-1.
  - Display content comes only from the snapshot. Input changes mid-frame never appear mid-frame.
- **Decode (active-low, bit order g..a):**
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
  - Any nibble >9 (invalid BCD): "E" = 0000110.
  - Dash positions: 0111111. Blank: 1111111.
- **Brightness:**
  - Sub-slot index `sub` = `scan_cnt` / (SCAN_DIV/8), range 0..7.
  - The digit is lit only while `sub` <= `brightness`.
  - Otherwise `an` = 8'hFF and `seg` = 7'h7F.
- **Blink:**
  - A `blink_cnt` counts 0..BLINK_DIV-1. On wrap, `blink_phase` toggles.
  - While `blink_phase`=1, positions in the selected field are blanked (`an`=8'hFF, `seg`=7'h7F).
  - Hour field = positions 6, 7; minute field = 3, 4; second field = 0, 1.
  - Dashes never blink.
  - `blink_sel` is sampled live, not snapshotted.
- **Lit slot:** exactly one `an` bit is low (`an` = ~(1<<pos)), and `seg` carries the decoded pattern.

## Timing
- **Reset** (async, immediate):
  - Outputs: `an`=8'hFF, `seg`=7'h7F.
  - Internal state: `scan_cnt`=0, `pos`=0, `blink_cnt`=0, `blink_phase`=0, snapshot=0.
  - Reset mid-frame abandons the frame.
- **Output latency:**
  - `an` and `seg` are registered and reflect `pos`/`scan_cnt`/`blink_phase` with 1-cycle latency.
  - The first lit output appears at posedge 2 after reset release, at position 0, showing the captured S0.
- **Snapshot timing:**
  - A snapshot taken at the end of the position-7 slot is first displayed in the position-0 slot that follows.
  - Full frame = 8·SCAN_DIV cycles.
- **Simultaneous events:**
  - `scan_cnt` wrap and `blink_cnt` wrap on the same cycle: both take effect on that edge.
  - `blink_sel` or `brightness` change: takes effect on the next registered output, with no frame alignment.
- **Outputs:** glitch-free; both are registered and never decoded combinationally.

## Test plan
All scenarios use SCAN_DIV=8 and BLINK_DIV=64.
- **Reset and first frame:** hold `resetn`=0 with inputs 12:34:56, then release.
  - Required: `an`=FF and `seg`=7F during reset.
  - Then, 8 cycles each: position 0 shows `seg`=0000010 ("6"), position 1 shows "5", position 2 shows dash 0111111, and so on through position 7 showing "1".
- **Snapshot integrity:** change inputs to 23:59:59 while `pos`=3.
  - Required: positions 4–7 still show 12:3x.
  - The next frame shows 23-59-59 throughout.
- **Brightness:** set `brightness`=1.
  - Required: each position is lit for `scan_cnt` 0–1, then `an`=FF for 6 cycles.
  - With `brightness`=7: continuous lit.
- **Blink:** set `blink_sel`=10.
  - Required: positions 3 and 4 are blanked during alternate 64-cycle windows.
  - Hour, second and dash positions are unaffected.
  - With `blink_sel`=00: no blanking.
- **Invalid BCD:** drive `second[0]`=4'hC.
  - Required: position 0 shows 0000110 ("E"); other positions are normal.
- **Async reset mid-frame:** assert `resetn` low at `pos`=5, between edges.
  - Required: `an`=FF immediately, without waiting for a clock edge.
  - After release, the scan restarts at position 0.

Source files
------------

// File: rtl/seg_scan_display.sv
// seg_scan_display: 8-digit multiplexed HH-MM-SS seven-segment driver with frame snapshot, blink and PWM brightness
module seg_scan_display #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [1:0][3:0] hour,
  input  logic [1:0][3:0] minute,
  input  logic [1:0][3:0] second,
  input  logic [1:0]      blink_sel,
  input  logic [2:0]      brightness,
  output logic [7:0]      an,
  output logic [6:0]      seg
);
  localparam int SW  = $clog2(SCAN_DIV);
  localparam int BW  = $clog2(BLINK_DIV);
  localparam int SUB = SCAN_DIV / 8;

  logic [SW-1:0]   scan_cnt;
  logic [BW-1:0]   blink_cnt;
  logic [2:0]      pos, idx, sub;
  logic            blink_phase, armed, scan_wrap, blink_wrap, dash, lit;
  logic [5:0][3:0] snap;
  logic [1:0]      field;
  logic [7:0]      an_d;
  logic [6:0]      seg_d;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0000110;
    endcase
  endfunction

  // positions 0,1 / 3,4 / 6,7 map onto snapshot digits 0..5; 2 and 5 are dashes
  always_comb begin
    scan_wrap  = scan_cnt == SW'(SCAN_DIV - 1);
    blink_wrap = blink_cnt == BW'(BLINK_DIV - 1);
    sub        = 3'(scan_cnt / SW'(SUB));
    idx        = 3'(pos - pos / 3'd3);
    dash       = pos == 3'd2 || pos == 3'd5;
    field      = pos < 3'd3 ? 2'b11 : pos < 3'd6 ? 2'b10 : 2'b01;
    lit        = armed && sub <= brightness && !(blink_phase && !dash && blink_sel == field);
    an_d       = lit ? ~(8'b1 << pos) : 8'hFF;
    seg_d      = !lit ? 7'h7F : dash ? 7'b0111111 : decode(snap[idx]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_cnt    <= '0;
      pos         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      armed       <= 1'b0;
      snap        <= '0;
      an          <= 8'hFF;
      seg         <= 7'h7F;
    end else begin
      scan_cnt    <= scan_wrap ? '0 : scan_cnt + 1'b1;
      pos         <= scan_wrap ? pos + 3'd1 : pos;
      blink_cnt   <= blink_wrap ? '0 : blink_cnt + 1'b1;
      blink_phase <= blink_wrap ? ~blink_phase : blink_phase;
      armed       <= 1'b1;
      if (!armed || (scan_wrap && pos == 3'd7)) snap <= {hour, minute, second};
      an          <= an_d;
      seg         <= seg_d;
    end
  end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed checks of scan order, snapshot, brightness, blink, invalid BCD and async reset
module tb_seg_scan_display;
  logic            clk = 1'b0;
  logic            resetn;
  logic [1:0][3:0] hour, minute, second;
  logic [1:0]      blink_sel;
  logic [2:0]      brightness;
  logic [7:0]      an;
  logic [6:0]      seg;
  int              n_checks = 0, n_pass = 0, edges = 0;

  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100, D3 = 7'b0110000,
                         D4 = 7'b0011001, D5 = 7'b0010010, D6 = 7'b0000010, D9 = 7'b0010000,
                         DASH = 7'b0111111, EE = 7'b0000110, BLANK = 7'h7F;

  seg_scan_display #(.SCAN_DIV(8), .BLINK_DIV(64)) dut (
    .clk(clk), .resetn(resetn), .hour(hour), .minute(minute), .second(second),
    .blink_sel(blink_sel), .brightness(brightness), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // advance to just after posedge number k counted from reset release
  task automatic goto_edge(input int k);
    while (edges < k) begin
      @(posedge clk);
      edges++;
    end
    #1;
  endtask

  // mid-slot sample of position p in frame f (edge 64f+8p+4 shows scan_cnt 3)
  task automatic check_pos(input string tag, input int f, input int p, input logic [7:0] an_exp,
                           input logic [6:0] seg_exp);
    goto_edge(64 * f + 8 * p + 4);
    check({tag, "_an"}, an, an_exp);
    check({tag, "_seg"}, {1'b0, seg}, {1'b0, seg_exp});
  endtask

  initial begin
    resetn = 1'b0; hour = 8'h12; minute = 8'h34; second = 8'h56;
    blink_sel = 2'b00; brightness = 3'd7;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", an, 8'hFF);
    check("rst_seg", {1'b0, seg}, {1'b0, BLANK});
    @(negedge clk) resetn = 1'b1;
    edges = 0;
    goto_edge(1);
    check("edge1_an", an, 8'hFF);
    goto_edge(2);
    check("edge2_an", an, 8'hFE);
    check("edge2_seg", {1'b0, seg}, {1'b0, D6});
    check_pos("f0p0", 0, 0, 8'hFE, D6);
    check_pos("f0p1", 0, 1, 8'hFD, D5);
    check_pos("f0p2", 0, 2, 8'hFB, DASH);
    check_pos("f0p3", 0, 3, 8'hF7, D4);
    hour = 8'h23; minute = 8'h59; second = 8'h59;
    check_pos("f0p4", 0, 4, 8'hEF, D3);
    check_pos("f0p5", 0, 5, 8'hDF, DASH);
    check_pos("f0p6", 0, 6, 8'hBF, D2);
    check_pos("f0p7", 0, 7, 8'h7F, D1);
    check_pos("f1p0", 1, 0, 8'hFE, D9);
    check_pos("f1p1", 1, 1, 8'hFD, D5);
    check_pos("f1p2", 1, 2, 8'hFB, DASH);
    check_pos("f1p3", 1, 3, 8'hF7, D9);
    check_pos("f1p4", 1, 4, 8'hEF, D5);
    check_pos("f1p5", 1, 5, 8'hDF, DASH);
    check_pos("f1p6", 1, 6, 8'hBF, D3);
    check_pos("f1p7", 1, 7, 8'h7F, D2);
    brightness = 3'd1;
    goto_edge(129);
    check("br_cnt0_an", an, 8'hFE);
    goto_edge(130);
    check("br_cnt1_an", an, 8'hFE);
    check("br_cnt1_seg", {1'b0, seg}, {1'b0, D9});
    goto_edge(131);
    check("br_cnt2_an", an, 8'hFF);
    check("br_cnt2_seg", {1'b0, seg}, {1'b0, BLANK});
    goto_edge(136);
    check("br_cnt7_an", an, 8'hFF);
    brightness = 3'd7;
    check_pos("br_full", 2, 1, 8'hFD, D5);
    blink_sel = 2'b10;
    check_pos("bl_off_p3", 2, 3, 8'hF7, D9);
    check_pos("bl_on_p0", 3, 0, 8'hFE, D9);
    check_pos("bl_on_p3", 3, 3, 8'hFF, BLANK);
    check_pos("bl_on_p4", 3, 4, 8'hFF, BLANK);
    check_pos("bl_on_p5", 3, 5, 8'hDF, DASH);
    check_pos("bl_on_p6", 3, 6, 8'hBF, D3);
    check_pos("bl_off_f4", 4, 3, 8'hF7, D9);
    blink_sel = 2'b00;
    check_pos("bl_none_f5", 5, 3, 8'hF7, D9);
    second = 8'h5C;
    check_pos("bad_p0", 6, 0, 8'hFE, EE);
    check_pos("bad_p1", 6, 1, 8'hFD, D5);
    check_pos("bad_p3", 6, 3, 8'hF7, D9);
    check_pos("pre_rst_p5", 6, 5, 8'hDF, DASH);
    #2 resetn = 1'b0;
    #1;
    check("async_an", an, 8'hFF);
    check("async_seg", {1'b0, seg}, {1'b0, BLANK});
    second = 8'h56;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    edges = 0;
    check_pos("restart_p0", 0, 0, 8'hFE, D6);
    check_pos("restart_p1", 0, 1, 8'hFD, D5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
